// File: rtl/hash_tuple_pkg.sv
// hash_tuple_pkg: shared constants, emitter states and helpers for the RSS tuple extractor
package hash_tuple_pkg;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0] IP_PROTO_TCP = 8'd6;
    localparam logic [7:0] IP_PROTO_UDP = 8'd17;
    localparam logic [1:0] HASH_TYPE_NONE = 2'd0;
    localparam logic [1:0] HASH_TYPE_IPV4 = 2'd1;
    localparam logic [1:0] HASH_TYPE_TCP = 2'd2;
    localparam logic [1:0] HASH_TYPE_UDP = 2'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SIP, ST_DIP, ST_PORTS, ST_DONE} emit_state_t;

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, keep[i]};
        return c;
    endfunction
endpackage

// File: rtl/hash_tuple_emit.sv
// hash_tuple_emit: holds one tuple and feeds it word-serially to the Toeplitz accumulator
module hash_tuple_emit
    import hash_tuple_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tuple_valid,
    input  logic [1:0]  tuple_type,
    input  logic [31:0] tuple_sip,
    input  logic [31:0] tuple_dip,
    input  logic [31:0] tuple_ports,
    output logic        busy,
    output logic [31:0] hash_data,
    output logic [1:0]  hash_data_len,
    output logic        hash_data_valid,
    output logic        hash_clear,
    output logic        hash_valid,
    output logic [1:0]  hash_type
);
    emit_state_t state, state_n;
    logic start;
    logic [1:0] typ;
    logic [31:0] sip, dip, ports;

    // start covers the latch cycle so a tuple arriving right behind is dropped, not overwritten
    assign busy = (state != ST_IDLE) || start;
    assign hash_data_len = 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            start <= 1'b0;
            typ <= HASH_TYPE_NONE;
            sip <= '0;
            dip <= '0;
            ports <= '0;
        end else begin
            state <= state_n;
            start <= tuple_valid;
            if (tuple_valid) begin
                typ <= tuple_type;
                sip <= tuple_sip;
                dip <= tuple_dip;
                ports <= tuple_ports;
            end
        end
    end

    always_comb begin
        state_n = state;
        hash_data = '0;
        hash_data_valid = 1'b0;
        hash_clear = 1'b0;
        hash_valid = 1'b0;
        hash_type = HASH_TYPE_NONE;
        case (state)
            ST_IDLE: state_n = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                hash_clear = 1'b1;
                state_n = (typ == HASH_TYPE_NONE) ? ST_DONE : ST_SIP;
            end
            ST_SIP: begin
                hash_data = sip;
                hash_data_valid = 1'b1;
                state_n = ST_DIP;
            end
            ST_DIP: begin
                hash_data = dip;
                hash_data_valid = 1'b1;
                state_n = (typ == HASH_TYPE_IPV4) ? ST_DONE : ST_PORTS;
            end
            ST_PORTS: begin
                hash_data = ports;
                hash_data_valid = 1'b1;
                state_n = ST_DONE;
            end
            ST_DONE: begin
                hash_valid = 1'b1;
                hash_type = typ;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/hash_tuple_extract.sv
// hash_tuple_extract: captures packet headers off a monitor tap and extracts the RSS tuple
module hash_tuple_extract
    import hash_tuple_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_BYTES = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic [31:0]           hash_data,
    output logic [1:0]            hash_data_len,
    output logic                  hash_data_valid,
    output logic                  hash_clear,
    output logic                  hash_valid,
    output logic [1:0]            hash_type,
    output logic                  tuple_drop
);
    localparam logic [3:0] LAST_BEAT = 4'(HDR_BYTES / 8 - 1);

    logic [HDR_BYTES*8-1:0] hdr, hdr_cur;
    logic [3:0] beat_cnt, ihl;
    logic [6:0] byte_cnt, byte_cur, p_off;
    logic [9:0] wr_base, port_base;
    logic [15:0] etype;
    logic [7:0] proto;
    logic cap_done, wr, complete, busy, ip_ok, l4_ok;
    logic [1:0] tuple_type;

    assign wr = s_axis_tvalid && !cap_done;
    assign wr_base = {beat_cnt, 6'd0};
    assign byte_cur = byte_cnt + {3'd0, keep_count(s_axis_tkeep)};
    assign complete = wr && (beat_cnt == LAST_BEAT || s_axis_tlast);

    // completion decodes the buffer as it will look after this beat is written
    always_comb begin
        hdr_cur = hdr;
        if (wr) hdr_cur[wr_base +: DATA_WIDTH] = s_axis_tdata;
    end

    assign etype = {hdr_cur[96 +: 8], hdr_cur[104 +: 8]};
    assign ihl = hdr_cur[112 +: 4];
    assign proto = hdr_cur[184 +: 8];
    assign p_off = 7'd14 + {1'b0, ihl, 2'b00};
    assign port_base = {p_off, 3'b000};
    assign ip_ok = etype == ETH_TYPE_IPV4 && hdr_cur[116 +: 4] == 4'd4 && ihl >= 4'd5 && byte_cur >= 7'd34;
    assign l4_ok = !hdr_cur[165] && {hdr_cur[160 +: 5], hdr_cur[168 +: 8]} == 13'd0 &&
                   (proto == IP_PROTO_TCP || proto == IP_PROTO_UDP) && byte_cur >= p_off + 7'd4;
    assign tuple_type = !ip_ok ? HASH_TYPE_NONE : !l4_ok ? HASH_TYPE_IPV4 :
                        (proto == IP_PROTO_TCP) ? HASH_TYPE_TCP : HASH_TYPE_UDP;

    always_ff @(posedge clk) hdr <= hdr_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            byte_cnt <= '0;
            cap_done <= 1'b0;
            tuple_drop <= 1'b0;
        end else begin
            tuple_drop <= complete && busy;
            if (s_axis_tvalid) begin
                if (s_axis_tlast) begin
                    beat_cnt <= '0;
                    byte_cnt <= '0;
                    cap_done <= 1'b0;
                end else if (!cap_done) begin
                    beat_cnt <= (beat_cnt == LAST_BEAT) ? beat_cnt : beat_cnt + 4'd1;
                    byte_cnt <= byte_cur;
                    cap_done <= beat_cnt == LAST_BEAT;
                end
            end
        end
    end

    hash_tuple_emit u_emit (
        .clk(clk),
        .rst(rst),
        .tuple_valid(complete && !busy),
        .tuple_type(tuple_type),
        .tuple_sip(hdr_cur[208 +: 32]),
        .tuple_dip(hdr_cur[240 +: 32]),
        .tuple_ports(hdr_cur[port_base +: 32]),
        .busy(busy),
        .hash_data(hash_data),
        .hash_data_len(hash_data_len),
        .hash_data_valid(hash_data_valid),
        .hash_clear(hash_clear),
        .hash_valid(hash_valid),
        .hash_type(hash_type)
    );
endmodule

// File: tb/tb_hash_tuple_extract.sv
// tb_hash_tuple_extract: directed packets with hand-computed tuple words and emit timing
module tb_hash_tuple_extract;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [63:0] tdata = '0;
    logic [7:0] tkeep = '0;
    logic tvalid = 1'b0;
    logic tlast = 1'b0;
    logic [31:0] hash_data;
    logic [1:0] hash_data_len, hash_type;
    logic hash_data_valid, hash_clear, hash_valid, tuple_drop;

    hash_tuple_extract dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast),
        .hash_data(hash_data),
        .hash_data_len(hash_data_len),
        .hash_data_valid(hash_data_valid),
        .hash_clear(hash_clear),
        .hash_valid(hash_valid),
        .hash_type(hash_type),
        .tuple_drop(tuple_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int n_clear, n_valid, n_drop, n_overlap = 0, n_badlen = 0;
    int clear_cyc, valid_cyc, word_cyc, comp_cyc, t1;
    logic [1:0] valid_type;
    logic [31:0] words[$];
    logic [7:0] pkt[128];

    always @(negedge clk) begin
        if (hash_clear) begin
            n_clear++;
            clear_cyc = cyc;
        end
        if (hash_data_valid) begin
            if (words.size() == 0) word_cyc = cyc;
            words.push_back(hash_data);
            if (hash_data_len != 2'd0) n_badlen++;
        end
        if (hash_clear && hash_data_valid) n_overlap++;
        if (hash_valid) begin
            n_valid++;
            valid_cyc = cyc;
            valid_type = hash_type;
        end
        if (tuple_drop) n_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        return (i < words.size()) ? words[i] : 32'hxxxxxxxx;
    endfunction

    task automatic mon_clear();
        @(posedge clk);
        n_clear = 0;
        n_valid = 0;
        n_drop = 0;
        clear_cyc = -1;
        valid_cyc = -1;
        word_cyc = -1;
        valid_type = 2'bxx;
        words.delete();
    endtask

    task automatic build(input logic [15:0] etype, input logic [3:0] ihl, input logic mf,
                         input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp);
        int p;
        for (int i = 0; i < 128; i++) pkt[i] = 8'(i * 7 + 3);
        p = 14 + int'(ihl) * 4;
        {pkt[12], pkt[13]} = etype;
        pkt[14] = {4'h4, ihl};
        pkt[20] = mf ? 8'h20 : 8'h00;
        pkt[21] = 8'h00;
        pkt[23] = proto;
        {pkt[26], pkt[27], pkt[28], pkt[29]} = sip;
        {pkt[30], pkt[31], pkt[32], pkt[33]} = dip;
        {pkt[p], pkt[p+1], pkt[p+2], pkt[p+3]} = {sp, dp};
    endtask

    task automatic send(input int len);
        bit done = 0;
        for (int b = 0; b * 8 < len; b++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                tdata[8*j +: 8] = (b * 8 + j < len) ? pkt[b*8+j] : 8'h00;
                tkeep[j] = (b * 8 + j < len);
            end
            tvalid = 1'b1;
            tlast = (b * 8 + 8 >= len);
            if (!done && (b == 9 || tlast)) begin
                comp_cyc = cyc;
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
        tkeep = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hash_data", hash_data, 0);
        chk("rst_data_valid", {31'd0, hash_data_valid}, 0);
        chk("rst_clear", {31'd0, hash_clear}, 0);
        chk("rst_hash_valid", {31'd0, hash_valid}, 0);
        chk("rst_type_drop", {hash_type, hash_data_len, tuple_drop}, 0);

        // IPv4/TCP 10.0.0.1:1234 -> 10.0.0.2:80
        mon_clear();
        build(16'h0800, 4'd5, 1'b0, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(64);
        idle(10);
        chk("tcp_clear_cnt", n_clear, 1);
        chk("tcp_clear_cyc", clear_cyc, comp_cyc + 2);
        chk("tcp_word_cnt", words.size(), 3);
        chk("tcp_sip", word_at(0), 32'h0100000A);
        chk("tcp_dip", word_at(1), 32'h0200000A);
        chk("tcp_ports", word_at(2), 32'h5000D204);
        chk("tcp_word_cyc", word_cyc, comp_cyc + 3);
        chk("tcp_valid_cyc", valid_cyc, comp_cyc + 6);
        chk("tcp_type", {30'd0, valid_type}, 2);

        // IPv4/UDP IHL=7, 192.168.1.10:53 -> 192.168.1.20:5353
        mon_clear();
        build(16'h0800, 4'd7, 1'b0, 8'd17, 32'hC0A8010A, 32'hC0A80114, 16'd53, 16'd5353);
        send(64);
        idle(10);
        chk("udp_sip", word_at(0), 32'h0A01A8C0);
        chk("udp_dip", word_at(1), 32'h1401A8C0);
        chk("udp_ports", word_at(2), 32'hE9143500);
        chk("udp_valid_cyc", valid_cyc, comp_cyc + 6);
        chk("udp_type", {30'd0, valid_type}, 3);

        // MF fragment: addresses only
        mon_clear();
        build(16'h0800, 4'd5, 1'b1, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(64);
        idle(10);
        chk("frag_word_cnt", words.size(), 2);
        chk("frag_dip", word_at(1), 32'h0200000A);
        chk("frag_valid_cyc", valid_cyc, comp_cyc + 5);
        chk("frag_type", {30'd0, valid_type}, 1);

        // ARP: clear then done
        mon_clear();
        build(16'h0806, 4'd5, 1'b0, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(64);
        idle(10);
        chk("arp_clear_cnt", n_clear, 1);
        chk("arp_word_cnt", words.size(), 0);
        chk("arp_valid_cyc", valid_cyc, comp_cyc + 3);
        chk("arp_type", {30'd0, valid_type}, 0);

        // IHL below minimum
        mon_clear();
        build(16'h0800, 4'd4, 1'b0, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(64);
        idle(10);
        chk("ihl4_type", {30'd0, valid_type}, 0);
        chk("ihl4_word_cnt", words.size(), 0);

        // 40-byte runt, IHL=6 so ports would need 42 bytes, then a back-to-back runt
        mon_clear();
        build(16'h0800, 4'd6, 1'b0, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(40);
        t1 = comp_cyc;
        send(40);
        idle(12);
        chk("runt_valid_cnt", n_valid, 1);
        chk("runt_type", {30'd0, valid_type}, 1);
        chk("runt_valid_cyc", valid_cyc, t1 + 5);
        chk("runt_word_cnt", words.size(), 2);
        chk("runt_clear_cnt", n_clear, 1);
        chk("runt_drop_cnt", n_drop, 1);

        // exactly 80 bytes: tlast coincides with beat 9
        mon_clear();
        build(16'h0800, 4'd5, 1'b0, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(80);
        idle(10);
        chk("b9last_valid_cnt", n_valid, 1);
        chk("b9last_valid_cyc", valid_cyc, comp_cyc + 6);
        chk("b9last_type", {30'd0, valid_type}, 3);

        // long packet: completion at beat 9, tail beats ignored
        mon_clear();
        build(16'h0800, 4'd15, 1'b0, 8'd6, 32'h01020304, 32'h05060708, 16'h1122, 16'h3344);
        send(128);
        idle(10);
        chk("long_valid_cnt", n_valid, 1);
        chk("long_ports", word_at(2), 32'h44332211);
        chk("long_sip", word_at(0), 32'h04030201);
        chk("long_type", {30'd0, valid_type}, 2);

        // reset while the port word is on the bus
        mon_clear();
        build(16'h0800, 4'd5, 1'b0, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(64);
        idle(0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = hash_data_valid && hash_data == 32'h5000D204;
        end
        chk("rst_wait_ports", {31'd0, found}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", hash_data, 0);
        chk("midrst_flags", {27'd0, hash_data_valid, hash_clear, hash_valid, tuple_drop, 1'b0}, 0);
        chk("midrst_type_len", {28'd0, hash_type, hash_data_len}, 0);
        rst = 1'b0;
        mon_clear();
        send(64);
        idle(10);
        chk("post_rst_clear_cnt", n_clear, 1);
        chk("post_rst_valid_cyc", valid_cyc, comp_cyc + 6);
        chk("post_rst_ports", word_at(2), 32'h5000D204);

        chk("no_clear_with_data", n_overlap, 0);
        chk("data_len_zero", n_badlen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
